// File: rtl/arb_pkg.sv
// Shared arbiter types: runtime mode encoding and default LFSR constants.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_FIXED = 2'd0,
    ARB_RR    = 2'd1,
    ARB_RAND  = 2'd2,
    ARB_OFF   = 2'd3
  } arb_mode_e;

  localparam int unsigned LFSR_W_DEF    = 8;
  localparam logic [7:0]  LFSR_TAPS_DEF = 8'hB8;
  localparam logic [7:0]  LFSR_SEED_DEF = 8'h01;

endpackage

// File: rtl/pn_lfsr.sv
// Free-running Fibonacci LFSR used as the random-priority source.
import arb_pkg::*;

module pn_lfsr #(
  parameter int unsigned         LFSR_W    = LFSR_W_DEF,
  parameter logic [LFSR_W-1:0]   LFSR_TAPS = LFSR_W'(LFSR_TAPS_DEF),
  parameter logic [LFSR_W-1:0]   LFSR_SEED = LFSR_W'(LFSR_SEED_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] out
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;

endmodule

// File: rtl/multi_mode_arbiter.sv
// N-requester arbiter: fixed / round-robin / random priority with bounded grant lock.
import arb_pkg::*;

module multi_mode_arbiter #(
  parameter int unsigned       N         = 4,
  parameter int unsigned       IDX_W     = $clog2(N),
  parameter int unsigned       LFSR_W    = LFSR_W_DEF,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(LFSR_TAPS_DEF),
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(LFSR_SEED_DEF),
  parameter int unsigned       MAX_HOLD  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [1:0]       mode,
  input  logic [IDX_W-1:0] pri_sel,
  input  logic             lock_en,
  output logic [N-1:0]     gnt,
  output logic             gnt_vld,
  output logic [IDX_W-1:0] gnt_idx
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  logic [N-1:0]      gnt_q, gnt_d;
  logic              gnt_vld_q, gnt_vld_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]  rr_last_q, rr_last_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  arb_mode_e         mode_q, mode_d;

  arb_mode_e         mode_e;
  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_unused;
  logic [IDX_W-1:0]  pri_start;
  logic [IDX_W-1:0]  rand_start;
  logic              lock_ok;
  logic [N-1:0]      arb_req;
  logic [IDX_W:0]    win;

  pn_lfsr #(
    .LFSR_W    (LFSR_W),
    .LFSR_TAPS (LFSR_TAPS),
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .out (lfsr)
  );

  // Returns {found, idx}. rotate=1: search s+1, s+2, ... mod N; else s first, then ascending from 0.
  function automatic logic [IDX_W:0] search(input logic [N-1:0] r, input logic [IDX_W-1:0] s,
                                            input logic rotate);
    logic             found;
    logic [IDX_W-1:0] idx;
    int               j;
    found = 1'b0;
    idx   = '0;
    if (rotate) begin
      for (int k = 1; k <= int'(N); k++) begin
        j = (int'(s) + k) % int'(N);
        if (!found && r[IDX_W'(j)]) begin
          found = 1'b1;
          idx   = IDX_W'(j);
        end
      end
    end else if (r[s]) begin
      found = 1'b1;
      idx   = s;
    end else begin
      for (int k = 0; k < int'(N); k++) begin
        if (!found && r[IDX_W'(k)]) begin
          found = 1'b1;
          idx   = IDX_W'(k);
        end
      end
    end
    return {found, idx};
  endfunction

  assign mode_e      = arb_mode_e'(mode);
  assign lfsr_unused = ^lfsr;
  assign pri_start   = (int'(pri_sel) < int'(N)) ? pri_sel : '0;
  assign rand_start  = IDX_W'(int'(lfsr[IDX_W-1:0]) % int'(N));
  assign lock_ok     = lock_en & gnt_vld_q & req[gnt_idx_q] & (mode_e == mode_q);

  // Holder is masked only at forced release, and only when someone else is waiting.
  always_comb begin
    arb_req = req;
    if (lock_ok && ((req & ~gnt_q) != '0)) arb_req = req & ~gnt_q;
  end

  always_comb begin
    win = '0;
    case (mode_e)
      ARB_RR:   win = search(arb_req, rr_last_q, 1'b1);
      ARB_RAND: win = search(arb_req, rand_start, 1'b0);
      default:  win = search(arb_req, pri_start, 1'b0);
    endcase
  end

  always_comb begin
    gnt_d      = '0;
    gnt_vld_d  = 1'b0;
    gnt_idx_d  = '0;
    rr_last_d  = rr_last_q;
    hold_cnt_d = '0;
    mode_d     = mode_e;
    if (mode_e != ARB_OFF && req != '0) begin
      if (lock_ok && hold_cnt_q < HOLD_W'(MAX_HOLD - 1)) begin
        gnt_d      = gnt_q;
        gnt_vld_d  = 1'b1;
        gnt_idx_d  = gnt_idx_q;
        rr_last_d  = gnt_idx_q;
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end else if (win[IDX_W]) begin
        gnt_d[win[IDX_W-1:0]] = 1'b1;
        gnt_vld_d             = 1'b1;
        gnt_idx_d             = win[IDX_W-1:0];
        rr_last_d             = win[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q      <= '0;
      gnt_vld_q  <= 1'b0;
      gnt_idx_q  <= '0;
      rr_last_q  <= IDX_W'(N - 1);
      hold_cnt_q <= '0;
      mode_q     <= ARB_OFF;
    end else begin
      gnt_q      <= gnt_d;
      gnt_vld_q  <= gnt_vld_d;
      gnt_idx_q  <= gnt_idx_d;
      rr_last_q  <= rr_last_d;
      hold_cnt_q <= hold_cnt_d;
      mode_q     <= mode_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = gnt_vld_q;
  assign gnt_idx = gnt_idx_q;

endmodule

// File: tb/tb_multi_mode_arbiter.sv
// Bench for multi_mode_arbiter: vector table, lock/mode sequences, random-mode LFSR model.
module tb_multi_mode_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [1:0] mode;
  logic [1:0] pri_sel;
  logic       lock_en;
  logic [3:0] gnt;
  logic       gnt_vld;
  logic [1:0] gnt_idx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [1:0] mode;
    logic [1:0] pri;
    logic       lock;
    logic [3:0] req;
    logic [3:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    string      tag;
  } exp_t;

  vec_t vecs[20];
  exp_t sb[$];
  logic [7:0] m_lfsr;

  multi_mode_arbiter #(.N(4), .MAX_HOLD(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .mode    (mode),
    .pri_sel (pri_sel),
    .lock_en (lock_en),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always #5 clk = ~clk;

  // Independent reference of the x^8+x^6+x^5+x^4+1 sequence.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'h01;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic vec_t mk(input logic r, input logic [1:0] m, input logic [1:0] p,
                              input logic l, input logic [3:0] rq, input logic [3:0] e);
    vec_t v;
    v.rst = r; v.mode = m; v.pri = p; v.lock = l; v.req = rq; v.exp = e;
    return v;
  endfunction

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] i;
    i = 2'd0;
    for (int k = 0; k < 4; k++) if (g[k]) i = 2'(k);
    return i;
  endfunction

  function automatic logic [3:0] rand_pick(input logic [3:0] r, input logic [1:0] s);
    logic [3:0] g;
    g = 4'b0000;
    if (r[s]) g[s] = 1'b1;
    else if (r[0]) g = 4'b0001;
    else if (r[1]) g = 4'b0010;
    else if (r[2]) g = 4'b0100;
    else if (r[3]) g = 4'b1000;
    return g;
  endfunction

  task automatic check_out();
    exp_t       x;
    logic [1:0] ei;
    x  = sb.pop_front();
    ei = idx_of(x.gnt);
    checks++;
    if (gnt !== x.gnt) begin
      errors++;
      $display("FAIL %s gnt got %b exp %b", x.tag, gnt, x.gnt);
    end
    checks++;
    if (gnt_vld !== (|x.gnt)) begin
      errors++;
      $display("FAIL %s gnt_vld got %b exp %b", x.tag, gnt_vld, |x.gnt);
    end
    checks++;
    if (gnt_idx !== ei) begin
      errors++;
      $display("FAIL %s gnt_idx got %0d exp %0d", x.tag, gnt_idx, ei);
    end
  endtask

  task automatic apply(input logic r, input logic [1:0] m, input logic [1:0] p, input logic l,
                       input logic [3:0] rq, input logic [3:0] e, input string tag);
    exp_t x;
    rst = r; mode = m; pri_sel = p; lock_en = l; req = rq;
    x.gnt = e;
    x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    logic [3:0] rq;

    // Reset, fixed priority, mid-grant reset, round robin, disable, fixed after RR.
    vecs[0]  = mk(1, 2'd0, 2'd2, 0, 4'b1111, 4'b0000);
    vecs[1]  = mk(1, 2'd0, 2'd2, 0, 4'b1111, 4'b0000);
    vecs[2]  = mk(0, 2'd0, 2'd2, 0, 4'b1111, 4'b0100);
    vecs[3]  = mk(0, 2'd0, 2'd1, 0, 4'b1101, 4'b0001);
    vecs[4]  = mk(0, 2'd0, 2'd1, 0, 4'b1100, 4'b0100);
    vecs[5]  = mk(0, 2'd0, 2'd1, 0, 4'b0000, 4'b0000);
    vecs[6]  = mk(0, 2'd0, 2'd3, 0, 4'b1000, 4'b1000);
    vecs[7]  = mk(1, 2'd1, 2'd0, 0, 4'b1111, 4'b0000);
    vecs[8]  = mk(0, 2'd1, 2'd0, 0, 4'b1111, 4'b0001);
    vecs[9]  = mk(0, 2'd1, 2'd0, 0, 4'b1111, 4'b0010);
    vecs[10] = mk(0, 2'd1, 2'd0, 0, 4'b1111, 4'b0100);
    vecs[11] = mk(0, 2'd1, 2'd0, 0, 4'b1111, 4'b1000);
    vecs[12] = mk(0, 2'd1, 2'd0, 0, 4'b1111, 4'b0001);
    vecs[13] = mk(0, 2'd1, 2'd0, 0, 4'b1010, 4'b0010);
    vecs[14] = mk(0, 2'd1, 2'd0, 0, 4'b1010, 4'b1000);
    vecs[15] = mk(0, 2'd1, 2'd0, 0, 4'b1010, 4'b0010);
    vecs[16] = mk(0, 2'd3, 2'd0, 0, 4'b1111, 4'b0000);
    vecs[17] = mk(0, 2'd1, 2'd0, 0, 4'b1111, 4'b0100);
    vecs[18] = mk(0, 2'd0, 2'd3, 0, 4'b0111, 4'b0001);
    vecs[19] = mk(1, 2'd1, 2'd0, 1, 4'b0011, 4'b0000);

    for (int i = 0; i < 20; i++)
      apply(vecs[i].rst, vecs[i].mode, vecs[i].pri, vecs[i].lock, vecs[i].req, vecs[i].exp,
            $sformatf("vec%0d", i));

    // Bounded lock in RR: each holder keeps the grant for MAX_HOLD cycles.
    for (int i = 0; i < 3; i++) apply(0, 2'd1, 2'd0, 1, 4'b0011, 4'b0001, $sformatf("lockA%0d", i));
    for (int i = 0; i < 3; i++) apply(0, 2'd1, 2'd0, 1, 4'b0011, 4'b0010, $sformatf("lockB%0d", i));
    for (int i = 0; i < 3; i++) apply(0, 2'd1, 2'd0, 1, 4'b0011, 4'b0001, $sformatf("lockC%0d", i));
    apply(0, 2'd1, 2'd0, 1, 4'b0011, 4'b0010, "lock_switch");
    // Holder 1 drops mid-hold; requester 0 is granted immediately.
    apply(0, 2'd1, 2'd0, 1, 4'b0001, 4'b0001, "holder_drop");
    // Sole requester past its hold limit is simply re-granted.
    for (int i = 0; i < 4; i++) apply(0, 2'd1, 2'd0, 1, 4'b0001, 4'b0001, $sformatf("sole%0d", i));

    // Locked on req0, disable, then RR resumes from rr_last+1.
    apply(0, 2'd1, 2'd0, 1, 4'b0011, 4'b0001, "pre_off_hold");
    apply(0, 2'd3, 2'd0, 1, 4'b0011, 4'b0000, "mode_off");
    apply(0, 2'd1, 2'd0, 1, 4'b0011, 4'b0010, "rr_resume");
    apply(0, 2'd1, 2'd0, 1, 4'b0011, 4'b0010, "rr_hold");
    // Mode change breaks the lock: fixed priority from requester 0 wins.
    apply(0, 2'd0, 2'd0, 1, 4'b0011, 4'b0001, "mode_chg_break");

    // Random priority against the LFSR reference model.
    for (int i = 0; i < 64; i++) begin
      rq = (i < 32) ? 4'b1111 : 4'($urandom_range(1, 15));
      apply(0, 2'd2, 2'd0, 0, rq, rand_pick(rq, m_lfsr[1:0]), $sformatf("rand%0d", i));
    end
    for (int i = 0; i < 5; i++) apply(0, 2'd2, 2'd0, 0, 4'b0000, 4'b0000, $sformatf("rand_idle%0d", i));
    for (int i = 0; i < 8; i++)
      apply(0, 2'd2, 2'd0, 0, 4'b1111, rand_pick(4'b1111, m_lfsr[1:0]), $sformatf("rand_post%0d", i));

    // Reset asserted during a grant clears everything on the next edge.
    apply(1, 2'd2, 2'd0, 1, 4'b1111, 4'b0000, "rst_mid");
    apply(0, 2'd1, 2'd0, 0, 4'b1111, 4'b0001, "post_rst_rr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
